// File: rtl/pm_arbiter.sv
// Single-port 16x8 program/data memory shared round-robin between fetch, store and loader.
// After every reset an init sequencer clears the whole array before any request is served.
module pm_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_ctrl,
   input  logic              rst_ctrl,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] fetch_data,
   input  logic              store_req,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              store_ack,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ack,
   output logic              busy,
   output logic [1:0]        grant_id
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [2:0]          ack_q, ack_d;
   logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;
   logic [1:0]          grant_id_q, grant_id_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [3:0]          elig;
   logic [1:0]          cand;
   logic [1:0]          win;
   logic                found;

   function automatic logic [1:0] rr_next(input logic [1:0] c);
      return (c >= 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   // Next-state, round-robin selection and memory access decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      ack_d        = 3'b000;
      fetch_data_d = fetch_data_q;
      grant_id_d   = grant_id_q;
      busy_d       = busy_q;
      mem_we       = 1'b0;
      mem_waddr    = cnt_q;
      mem_wdata    = '0;

      // a requester is masked during its own ack cycle
      elig  = {1'b0, load_req & ~ack_q[2], store_req & ~ack_q[1], fetch_req & ~ack_q[0]};
      cand  = rr_next(ptr_q);
      win   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!found && elig[cand]) begin
            win   = cand;
            found = 1'b1;
         end
         cand = rr_next(cand);
      end

      case (state_q)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            cnt_d     = ADDR_W'(cnt_q + 1'b1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
               busy_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (found) begin
               ptr_d      = win;
               grant_id_d = win;
               ack_d[win] = 1'b1;
               case (win)
                  2'd0: fetch_data_d = mem_q[fetch_addr];
                  2'd1: begin
                     mem_we    = 1'b1;
                     mem_waddr = store_addr;
                     mem_wdata = store_data;
                  end
                  default: begin
                     mem_we    = 1'b1;
                     mem_waddr = load_addr;
                     mem_wdata = load_data;
                  end
               endcase
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_ctrl) begin
      if (rst_ctrl) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         ptr_q        <= 2'd2;
         ack_q        <= 3'b000;
         fetch_data_q <= '0;
         grant_id_q   <= 2'd3;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         ack_q        <= ack_d;
         fetch_data_q <= fetch_data_d;
         grant_id_q   <= grant_id_d;
         busy_q       <= busy_d;
      end
   end

   // Reset cancels any access decided in the same cycle
   always_ff @(posedge clk_ctrl) begin
      if (mem_we && !rst_ctrl) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign fetch_ack  = ack_q[0];
   assign store_ack  = ack_q[1];
   assign load_ack   = ack_q[2];
   assign fetch_data = fetch_data_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_pm_arbiter.sv
// Bench for pm_arbiter: cycle-level reference model plus directed handshake scenarios.
module tb_pm_arbiter;

   logic       clk_ctrl = 1'b0;
   logic       rst_ctrl = 1'b0;
   logic       fetch_req = 1'b0, store_req = 1'b0, load_req = 1'b0;
   logic [3:0] fetch_addr = '0, store_addr = '0, load_addr = '0;
   logic [7:0] store_data = '0, load_data = '0;
   logic       fetch_ack, store_ack, load_ack, busy;
   logic [7:0] fetch_data;
   logic [1:0] grant_id;

   int n_pass = 0;
   int n_total = 0;

   pm_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk_ctrl(clk_ctrl), .rst_ctrl(rst_ctrl),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .store_req(store_req), .store_addr(store_addr), .store_data(store_data), .store_ack(store_ack),
      .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk_ctrl = ~clk_ctrl;

   // reference model: memory as an array, arbitration as a modular search
   logic [7:0] m_mem [16];
   int         m_init_left = 0;
   int         m_ptr = 2;
   logic [2:0] m_ack = '0;
   logic [7:0] m_fdata = '0;
   int         m_gid = 3;
   logic       m_busy = 1'b0;
   bit         m_valid = 1'b0;

   always @(posedge clk_ctrl) begin
      logic [2:0] req;
      int win;
      int c;
      if (rst_ctrl) begin
         m_valid = 1'b1; m_init_left = 16; m_ptr = 2; m_ack = '0;
         m_fdata = '0; m_gid = 3; m_busy = 1'b1;
      end else if (m_valid) begin
         if (m_init_left > 0) begin
            m_mem[16 - m_init_left] = 8'h00;
            m_init_left--;
            m_busy = (m_init_left > 0);
            m_ack = '0;
         end else begin
            req = {load_req, store_req, fetch_req};
            win = -1;
            for (int k = 0; k < 3; k++) begin
               c = (m_ptr + 1 + k) % 3;
               if (win < 0 && req[c] && !m_ack[c]) win = c;
            end
            m_ack = '0;
            if (win >= 0) begin
               m_ack[win] = 1'b1;
               m_ptr = win;
               m_gid = win;
               if (win == 0) m_fdata = m_mem[fetch_addr];
               else if (win == 1) m_mem[store_addr] = store_data;
               else m_mem[load_addr] = load_data;
            end
         end
      end
   end

   always @(negedge clk_ctrl) begin
      if (m_valid) begin
         n_total++;
         if ({fetch_ack, store_ack, load_ack, busy, grant_id, fetch_data} ===
             {m_ack[0], m_ack[1], m_ack[2], m_busy, 2'(m_gid), m_fdata})
            n_pass++;
         else
            $display("FAIL model_cycle t=%0t: got ack(f,s,l)=%b%b%b busy=%b gid=%0d data=%h, required ack=%b%b%b busy=%b gid=%0d data=%h",
                     $time, fetch_ack, store_ack, load_ack, busy, grant_id, fetch_data,
                     m_ack[0], m_ack[1], m_ack[2], m_busy, m_gid, m_fdata);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic logic [2:0] acks();
      return {load_ack, store_ack, fetch_ack};
   endfunction

   task automatic post_reset_checks();
      int n;
      check("reset_outputs", int'({acks(), busy, grant_id}), int'({3'b000, 1'b1, 2'd3}));
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk_ctrl);
      end
      check("busy_cycles", n, 16);
   endtask

   task automatic do_reset();
      fetch_req = 0; store_req = 0; load_req = 0;
      rst_ctrl = 1;
      @(negedge clk_ctrl);
      rst_ctrl = 0;
      post_reset_checks();
   endtask

   // single requester handshake; returns cycles from request to ack
   task automatic access(input int id, input logic [3:0] a, input logic [7:0] d, output int lat);
      case (id)
         0: begin fetch_addr = a; fetch_req = 1; end
         1: begin store_addr = a; store_data = d; store_req = 1; end
         default: begin load_addr = a; load_data = d; load_req = 1; end
      endcase
      lat = 0;
      do begin
         @(negedge clk_ctrl);
         lat++;
      end while (!acks()[id] && lat < 10);
      if (!acks()[id]) check("ack_timeout", 0, 1);
      fetch_req = 0; store_req = 0; load_req = 0;
   endtask

   task automatic fetch_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
      int lat;
      access(0, a, 8'h00, lat);
      check(name, int'(fetch_data), int'(exp));
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int lat;
      int ord [4];
      int gid [4];
      int cyc [4];
      int n, cy;
      int seq [8];
      logic [2:0] a;

      // power-up reset, preload through the loader, then reset again
      do_reset();
      access(2, 4'd2, 8'hAA, lat);
      access(2, 4'd7, 8'h3C, lat);
      do_reset();
      access(0, 4'd0, 8'h00, lat);
      check("first_fetch_lat", lat, 1);
      check("init_clear_0", int'(fetch_data), 0);
      for (int i = 1; i < 16; i++) fetch_chk("init_clear", 4'(i), 8'h00);

      // single fetch after a load
      access(2, 4'd3, 8'h50, lat);
      check("load_lat", lat, 1);
      access(0, 4'd3, 8'h00, lat);
      check("fetch_lat", lat, 1);
      check("fetch_data", int'(fetch_data), 8'h50);
      @(negedge clk_ctrl);
      check("fetch_hold", int'({fetch_ack, fetch_data}), int'({1'b0, 8'h50}));

      // three-way contention right after init
      do_reset();
      fetch_addr = 4'd5; store_addr = 4'd5; store_data = 8'h0D;
      load_addr = 4'd6; load_data = 8'hF0;
      fetch_req = 1; store_req = 1; load_req = 1;
      n = 0; cy = 0;
      while (n < 3 && cy < 10) begin
         @(negedge clk_ctrl);
         cy++;
         a = acks();
         for (int i = 0; i < 3; i++) if (a[i] && n < 4) begin
            ord[n] = i; gid[n] = int'(grant_id); cyc[n] = cy; n++;
         end
         if (a[0]) fetch_req = 0;
         if (a[1]) store_req = 0;
         if (a[2]) load_req = 0;
      end
      fetch_req = 0; store_req = 0; load_req = 0;
      check("tri_count", n, 3);
      if (n == 3) begin
         check("tri_order", ord[0] * 16 + ord[1] * 4 + ord[2], 6);
         check("tri_gid", gid[0] * 16 + gid[1] * 4 + gid[2], 6);
         check("tri_cycles", cyc[0] * 16 + cyc[1] * 4 + cyc[2], 16 + 8 + 3);
      end
      fetch_chk("tri_mem5", 4'd5, 8'h0D);
      fetch_chk("tri_mem6", 4'd6, 8'hF0);

      // fairness: fetch held, store re-requests; pointer is 0 here
      fetch_addr = 4'd1; store_addr = 4'd8; store_data = 8'h22;
      fetch_req = 1; store_req = 1;
      n = 0; cy = 0;
      while (n < 8 && cy < 20) begin
         @(negedge clk_ctrl);
         cy++;
         if (acks() != 3'b000) begin seq[n] = int'(grant_id); n++; end
         store_req = !store_ack;
      end
      check("fair_count", n, 8);
      for (int i = 0; i < 8; i++) check("fair_alt", seq[i], (i % 2 == 0) ? 1 : 0);
      load_addr = 4'd10; load_data = 8'h33; load_req = 1;
      n = 0; cy = 0;
      while (!load_ack && cy < 10) begin
         @(negedge clk_ctrl);
         cy++;
         if (acks() != 3'b000) n++;
         store_req = !store_ack && !load_ack;
      end
      fetch_req = 0; store_req = 0; load_req = 0;
      check("fair_load_grants", n, 2);

      // store and fetch to the same address with pointer at 2
      fetch_addr = 4'd9; store_addr = 4'd9; store_data = 8'h11;
      fetch_req = 1; store_req = 1;
      n = 0; cy = 0;
      while (n < 2 && cy < 10) begin
         @(negedge clk_ctrl);
         cy++;
         if (fetch_ack) begin
            check("same_addr_fetch_first", n, 0);
            check("same_addr_old_data", int'(fetch_data), 8'h00);
            fetch_req = 0; n++;
         end
         if (store_ack) begin store_req = 0; n++; end
      end
      fetch_req = 0; store_req = 0;
      check("same_addr_done", n, 2);
      fetch_chk("same_addr_new_data", 4'd9, 8'h11);

      // reset in the cycle a load would be granted
      load_addr = 4'd4; load_data = 8'h77; load_req = 1;
      rst_ctrl = 1;
      @(negedge clk_ctrl);
      rst_ctrl = 0; load_req = 0;
      post_reset_checks();
      fetch_chk("midrst_mem4", 4'd4, 8'h00);
      fetch_chk("midrst_mem3", 4'd3, 8'h00);
      fetch_chk("midrst_mem10", 4'd10, 8'h00);
      check("model_mem10_pin", int'(m_mem[10]), 0);

      @(negedge clk_ctrl);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
